pc_gen: RTL and testbench

- Fetch-stage PC generator for the pipelined MIPS core.
- Holds the F-stage PC register and computes the next PC from the D-stage control-flow decision.
- Adds stall hold, exception/eret redirection and a one-entry pending-redirect buffer for redirects that arrive under stall.
- Generalised in address width, reset vector and exception vector; sits between the D-stage comparator/decoder and instruction memory.

---
 rtl/pc_gen_pkg.sv | 19 +
 rtl/pc_target_mux.sv | 55 +++++
 rtl/pc_gen.sv | 86 ++++++++
 tb/tb_pc_gen.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared encodings and default vectors for the fetch-stage PC generator.
package pc_gen_pkg;

  localparam int unsigned NPC_TYPE_W    = 3;
  localparam int unsigned INSTR_INDEX_W = 26;

  typedef enum logic [NPC_TYPE_W-1:0] {
    NPC_NORMAL = 3'd0,
    NPC_BRANCH = 3'd1,
    NPC_J      = 3'd2,
    NPC_JR     = 3'd3
  } npc_type_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_EXC_PC   = 32'h0000_4180;
  // Last legal word offset of the fetch window above the reset vector.
  localparam logic [31:0] FETCH_WINDOW     = 32'h0000_3FFC;

endpackage

// File: rtl/pc_target_mux.sv
// Next-PC target calculation and priority select for the fetch stage.
module pc_target_mux
  import pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter logic [31:0] EXC_PC = DEFAULT_EXC_PC
) (
  input  logic [ADDR_W-1:0]        f_pc,
  input  logic [NPC_TYPE_W-1:0]    npc_type,
  input  logic                     cmp_res,
  input  logic [ADDR_W-1:0]        imm,
  input  logic [INSTR_INDEX_W-1:0] instr_index,
  input  logic [ADDR_W-1:0]        jr_addr,
  input  logic [ADDR_W-1:0]        d_pc,
  input  logic                     exc_req,
  input  logic                     eret_req,
  input  logic [ADDR_W-1:0]        epc,
  input  logic                     pend_valid,
  input  logic [ADDR_W-1:0]        pend_target,
  output logic [ADDR_W-1:0]        npc
);

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] j_pc;

  assign seq_pc = f_pc + ADDR_W'(4);
  assign br_pc  = d_pc + ADDR_W'(4) + (imm << 2);

  // J keeps the region bits of the D-stage PC above bit 27.
  if (ADDR_W > 28) begin : g_j_region
    assign j_pc = {d_pc[ADDR_W-1:28], instr_index, 2'b00};
  end else begin : g_j_flat
    assign j_pc = {instr_index, 2'b00};
  end

  always_comb begin
    npc = seq_pc;
    if (exc_req) begin
      npc = ADDR_W'(EXC_PC);
    end else if (eret_req) begin
      npc = epc;
    end else if (pend_valid) begin
      npc = pend_target;
    end else begin
      case (npc_type)
        NPC_BRANCH: npc = cmp_res ? br_pc : seq_pc;
        NPC_J:      npc = j_pc;
        NPC_JR:     npc = jr_addr;
        default:    npc = seq_pc;
      endcase
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC register with stall hold and a one-entry pending redirect.
// Optional fetch address check enabled by defining PC_ALIGN_CHECK_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_PC   = DEFAULT_EXC_PC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic [NPC_TYPE_W-1:0]    npc_type,
  input  logic                     cmp_res,
  input  logic [ADDR_W-1:0]        imm,
  input  logic [INSTR_INDEX_W-1:0] instr_index,
  input  logic [ADDR_W-1:0]        jr_addr,
  input  logic [ADDR_W-1:0]        d_pc,
  input  logic                     exc_req,
  input  logic                     eret_req,
  input  logic [ADDR_W-1:0]        epc,
  output logic [ADDR_W-1:0]        f_pc,
  output logic [ADDR_W-1:0]        npc,
  output logic                     pend_valid,
  output logic                     f_adel
);

  logic [ADDR_W-1:0] f_pc_q;
  logic [ADDR_W-1:0] pend_target_q;
  logic              pend_valid_q;
  logic              pend_is_exc_q;

  pc_target_mux #(
    .ADDR_W (ADDR_W),
    .EXC_PC (EXC_PC)
  ) u_target_mux (
    .f_pc        (f_pc_q),
    .npc_type    (npc_type),
    .cmp_res     (cmp_res),
    .imm         (imm),
    .instr_index (instr_index),
    .jr_addr     (jr_addr),
    .d_pc        (d_pc),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .pend_valid  (pend_valid_q),
    .pend_target (pend_target_q),
    .npc         (npc)
  );

  // Exceptions always win the pending slot; an eret never displaces one.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_q        <= ADDR_W'(RESET_PC);
      pend_target_q <= '0;
      pend_valid_q  <= 1'b0;
      pend_is_exc_q <= 1'b0;
    end else if (!stall) begin
      f_pc_q        <= npc;
      pend_valid_q  <= 1'b0;
      pend_is_exc_q <= 1'b0;
    end else if (exc_req) begin
      pend_target_q <= ADDR_W'(EXC_PC);
      pend_valid_q  <= 1'b1;
      pend_is_exc_q <= 1'b1;
    end else if (eret_req && !(pend_valid_q && pend_is_exc_q)) begin
      pend_target_q <= epc;
      pend_valid_q  <= 1'b1;
      pend_is_exc_q <= 1'b0;
    end
  end

  assign f_pc       = f_pc_q;
  assign pend_valid = pend_valid_q;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] WIN_LO = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] WIN_HI = ADDR_W'(RESET_PC + FETCH_WINDOW);

  assign f_adel = (f_pc_q[1:0] != 2'b00) || (f_pc_q < WIN_LO) || (f_pc_q > WIN_HI);
`else
  assign f_adel = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: vector table plus multi-cycle pending sequences.
module tb_pc_gen;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  npc_type;
  logic        cmp_res;
  logic [31:0] imm;
  logic [25:0] instr_index;
  logic [31:0] jr_addr;
  logic [31:0] d_pc;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] f_pc;
  logic [31:0] npc;
  logic        pend_valid;
  logic        f_adel;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        stl;
    logic [2:0]  typ;
    logic        cmp;
    logic [31:0] imm;
    logic [25:0] idx;
    logic [31:0] jr;
    logic [31:0] dpc;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic        chk_npc;
    logic [31:0] exp_npc;
    logic [31:0] exp_pc;
    logic        exp_pend;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic        pend;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  pc_gen dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .npc_type    (npc_type),
    .cmp_res     (cmp_res),
    .imm         (imm),
    .instr_index (instr_index),
    .jr_addr     (jr_addr),
    .d_pc        (d_pc),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .f_pc        (f_pc),
    .npc         (npc),
    .pend_valid  (pend_valid),
    .f_adel      (f_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(logic rst, logic stl, logic [2:0] typ, logic cmp, logic [31:0] im,
                             logic [25:0] idx, logic [31:0] jr, logic [31:0] dpc, logic exc,
                             logic eret, logic [31:0] ep, logic chk, logic [31:0] enpc,
                             logic [31:0] epc_exp, logic epend);
    vec_t t;
    t.rst = rst; t.stl = stl; t.typ = typ; t.cmp = cmp; t.imm = im; t.idx = idx;
    t.jr = jr; t.dpc = dpc; t.exc = exc; t.eret = eret; t.epc = ep;
    t.chk_npc = chk; t.exp_npc = enpc; t.exp_pc = epc_exp; t.exp_pend = epend;
    return t;
  endfunction

  function automatic logic adel_exp(logic [31:0] pc);
`ifdef PC_ALIGN_CHECK_EN
    return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, i, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int i);
    exp_t e;
    reset = t.rst; stall = t.stl; npc_type = t.typ; cmp_res = t.cmp; imm = t.imm;
    instr_index = t.idx; jr_addr = t.jr; d_pc = t.dpc; exc_req = t.exc;
    eret_req = t.eret; epc = t.epc;
    #1;
    if (t.chk_npc) check("npc", i, npc, t.exp_npc);
    sb.push_back('{i, t.exp_pc, t.exp_pend});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("f_pc", e.idx, f_pc, e.pc);
    check("pend_valid", e.idx, 32'(pend_valid), 32'(e.pend));
    check("f_adel", e.idx, 32'(f_adel), 32'(adel_exp(e.pc)));
  endtask

  initial begin
    int n;
    //            rst stl typ cmp imm           idx        jr            dpc           exc eret epc          chk npc           f_pc          pend
    vecs.push_back(v(1, 0, 0, 0, 32'h0,        26'h0,     32'h0,        32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0000_3000, 0));
    vecs.push_back(v(1, 0, 0, 0, 32'h0,        26'h0,     32'h0,        32'h0,        0, 0, 32'h0,        1, 32'h0000_3004, 32'h0000_3000, 0));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,        26'h0,     32'h0,        32'h0,        0, 0, 32'h0,        1, 32'h0000_3004, 32'h0000_3004, 0));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,        26'h0,     32'h0,        32'h0,        0, 0, 32'h0,        1, 32'h0000_3008, 32'h0000_3008, 0));
    vecs.push_back(v(0, 0, 1, 1, 32'hFFFF_FFFE, 26'h0,    32'h0,        32'h0000_3004, 0, 0, 32'h0,       1, 32'h0000_3000, 32'h0000_3000, 0));
    vecs.push_back(v(0, 0, 1, 0, 32'hFFFF_FFFE, 26'h0,    32'h0,        32'h0000_3004, 0, 0, 32'h0,       1, 32'h0000_3004, 32'h0000_3004, 0));
    vecs.push_back(v(0, 0, 2, 0, 32'h0,        26'h0C40,  32'h0,        32'h0000_3010, 0, 0, 32'h0,       1, 32'h0000_3100, 32'h0000_3100, 0));
    vecs.push_back(v(0, 0, 3, 0, 32'h0,        26'h0,     32'h0000_3048, 32'h0,       0, 0, 32'h0,        1, 32'h0000_3048, 32'h0000_3048, 0));
    vecs.push_back(v(0, 0, 3, 0, 32'h0,        26'h0,     32'h0000_3020, 32'h0,       0, 0, 32'h0,        1, 32'h0000_3020, 32'h0000_3020, 0));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        26'h0,     32'h0,        32'h0,        0, 0, 32'h0,        1, 32'h0000_3024, 32'h0000_3020, 0));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        26'h0,     32'h0,        32'h0,        0, 0, 32'h0,        1, 32'h0000_3024, 32'h0000_3020, 0));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        26'h0,     32'h0,        32'h0,        0, 0, 32'h0,        1, 32'h0000_3024, 32'h0000_3020, 0));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,        26'h0,     32'h0,        32'h0,        0, 0, 32'h0,        1, 32'h0000_3024, 32'h0000_3024, 0));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        26'h0,     32'h0,        32'h0,        0, 1, 32'h0000_3050, 1, 32'h0000_3050, 32'h0000_3024, 1));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        26'h0,     32'h0,        32'h0,        1, 0, 32'h0,        1, 32'h0000_4180, 32'h0000_3024, 1));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        26'h0,     32'h0,        32'h0,        0, 1, 32'h0000_3060, 1, 32'h0000_3060, 32'h0000_3024, 1));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        26'h0,     32'h0,        32'h0,        0, 0, 32'h0,        1, 32'h0000_4180, 32'h0000_3024, 1));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,        26'h0,     32'h0,        32'h0,        0, 0, 32'h0,        1, 32'h0000_4180, 32'h0000_4180, 0));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,        26'h0,     32'h0,        32'h0,        0, 0, 32'h0,        1, 32'h0000_4184, 32'h0000_4184, 0));
    vecs.push_back(v(0, 0, 3, 0, 32'h0,        26'h0,     32'h0000_3000, 32'h0,       1, 0, 32'h0,        1, 32'h0000_4180, 32'h0000_4180, 0));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,        26'h0,     32'h0,        32'h0,        0, 1, 32'h0000_3050, 1, 32'h0000_3050, 32'h0000_3050, 0));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        26'h0,     32'h0,        32'h0,        0, 1, 32'h0000_3070, 1, 32'h0000_3070, 32'h0000_3050, 1));
    vecs.push_back(v(0, 0, 2, 0, 32'h0,        26'h0C40,  32'h0,        32'h0000_3010, 0, 0, 32'h0,       1, 32'h0000_3070, 32'h0000_3070, 0));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,        26'h0,     32'h0,        32'h0,        1, 0, 32'h0,        1, 32'h0000_4180, 32'h0000_3070, 1));
    vecs.push_back(v(1, 1, 0, 0, 32'h0,        26'h0,     32'h0,        32'h0,        1, 0, 32'h0,        1, 32'h0000_4180, 32'h0000_3000, 0));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,        26'h0,     32'h0,        32'h0,        0, 0, 32'h0,        1, 32'h0000_3004, 32'h0000_3004, 0));
    vecs.push_back(v(0, 0, 1, 1, 32'h0000_0001, 26'h0,    32'h0,        32'hFFFF_FFF8, 0, 0, 32'h0,       1, 32'h0000_0000, 32'h0000_0000, 0));
    vecs.push_back(v(0, 0, 3, 0, 32'h0,        26'h0,     32'h0000_3002, 32'h0,       0, 0, 32'h0,        1, 32'h0000_3002, 32'h0000_3002, 0));
    vecs.push_back(v(0, 0, 3, 0, 32'h0,        26'h0,     32'h0000_8000, 32'h0,       0, 0, 32'h0,        1, 32'h0000_8000, 32'h0000_8000, 0));
    vecs.push_back(v(0, 0, 3, 0, 32'h0,        26'h0,     32'h0000_3004, 32'h0,       0, 0, 32'h0,        1, 32'h0000_3004, 32'h0000_3004, 0));
    vecs.push_back(v(0, 0, 5, 0, 32'h0,        26'h0,     32'h0,        32'h0,        0, 0, 32'h0,        1, 32'h0000_3008, 32'h0000_3008, 0));
    vecs.push_back(v(0, 0, 2, 0, 32'h0,        26'h0C40,  32'h0,        32'hA000_0010, 0, 0, 32'h0,       1, 32'hA000_3100, 32'hA000_3100, 0));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,        26'h0,     32'h0,        32'h0,        0, 0, 32'h0,        1, 32'hA000_3104, 32'hA000_3104, 0));

    foreach (vecs[i]) apply(vecs[i], i);

    // Exception held pending through a stall of random length.
    apply(v(0, 1, 0, 0, 32'h0, 26'h0, 32'h0, 32'h0, 1, 0, 32'h0, 1, 32'h0000_4180, 32'hA000_3104, 1), 100);
    n = $urandom_range(2, 6);
    for (int k = 0; k < n; k++)
      apply(v(0, 1, 3, 0, 32'h0, 26'h0, 32'h0000_3000, 32'h0, 0, 0, 32'h0, 1, 32'h0000_4180, 32'hA000_3104, 1), 101 + k);
    apply(v(0, 0, 3, 0, 32'h0, 26'h0, 32'h0000_3000, 32'h0, 0, 0, 32'h0, 1, 32'h0000_4180, 32'h0000_4180, 0), 110);

    // A later eret replaces an earlier pending eret.
    apply(v(0, 1, 0, 0, 32'h0, 26'h0, 32'h0, 32'h0, 0, 1, 32'h0000_3200, 1, 32'h0000_3200, 32'h0000_4180, 1), 120);
    apply(v(0, 1, 0, 0, 32'h0, 26'h0, 32'h0, 32'h0, 0, 1, 32'h0000_3300, 1, 32'h0000_3300, 32'h0000_4180, 1), 121);
    apply(v(0, 0, 0, 0, 32'h0, 26'h0, 32'h0, 32'h0, 0, 0, 32'h0,        1, 32'h0000_3300, 32'h0000_3300, 0), 122);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
